// File: rtl/run_pkg.sv
// Shared types and default constants for the run sequencer and its bench.
// The owner code tells the memory mux who may drive dat_mem this cycle.
package run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } run_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_CORE = 2'd2
  } owner_t;

  localparam int DONE_PC_DEFAULT = 460;
  localparam int TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/dmem_mux.sv
// Combinational owner select for the single dat_mem port.
// The host sees a grant and read data only when it owns the port.
module dmem_mux
  import run_pkg::*;
#(
  parameter int AW = 8
) (
  input  owner_t          owner,
  input  logic            host_req,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [7:0]      host_wdata,
  output logic            host_gnt,
  output logic [7:0]      host_rdata,
  input  logic [AW-1:0]   core_addr,
  input  logic [7:0]      core_wdata,
  input  logic            core_we,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_wdata,
  output logic            mem_we,
  input  logic [7:0]      mem_rdata
);

  always_comb begin
    host_gnt   = 1'b0;
    host_rdata = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (owner)
      OWN_HOST: begin
        host_gnt   = host_req;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        mem_we     = host_we && host_req;
        host_rdata = host_req ? mem_rdata : 8'h00;
      end
      OWN_CORE: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_we;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/run_sequencer.sv
// Run controller: parks the core, lets the host access data memory while parked,
// runs the program until the done PC or a cycle-count timeout.
module run_sequencer
  import run_pkg::*;
#(
  parameter int D       = 12,
  parameter int AW      = 8,
  parameter int DONE_PC = DONE_PC_DEFAULT,
  parameter int CW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            host_go,
  input  logic            host_req,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [7:0]      host_wdata,
  output logic            host_gnt,
  output logic [7:0]      host_rdata,
  input  logic [AW-1:0]   core_addr,
  input  logic [7:0]      core_wdata,
  input  logic            core_we,
  input  logic [D-1:0]    core_pc,
  output logic            core_start,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_wdata,
  output logic            mem_we,
  input  logic [7:0]      mem_rdata,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [CW-1:0]   cycle_cnt,
  output run_state_t      state_dbg
);

  localparam logic [D-1:0]  DONE_PC_V = D'(DONE_PC);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

  run_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  owner_t        owner;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Done wins over timeout when both hit in the same RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner   = OWN_HOST;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (host_go) state_d = ST_START;
      end
      ST_START: begin
        owner   = OWN_NONE;
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        owner = OWN_CORE;
        cnt_d = cnt_q + CW'(1);
        if (core_pc == DONE_PC_V)   state_d = ST_DONE;
        else if (cnt_q == CNT_LAST) state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign core_start = (state_q != ST_RUN);
  assign busy       = (state_q == ST_START) || (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign timeout    = (state_q == ST_FAULT);
  assign cycle_cnt  = cnt_q;
  assign state_dbg  = state_q;

  dmem_mux #(.AW(AW)) u_mux (
    .owner      (owner),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rdata (host_rdata),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: dut_a uses the default timeout, dut_b a 16-cycle timeout.
// Handshake: host_gnt is combinational from host_req and owner; a write lands at the edge ending a granted cycle.
module tb_run_sequencer;
  import run_pkg::*;

  localparam int D  = 12;
  localparam int AW = 8;
  localparam int CW = 16;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          host_go, host_req, host_we, mem_clr;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [D-1:0]  pc_base, pc_step;

  // per-instance core model and memory
  logic [D-1:0]  pc_a, pc_b;
  logic [AW-1:0] core_addr_a, core_addr_b, mem_addr_a, mem_addr_b;
  logic          core_we_a, core_we_b, core_start_a, core_start_b;
  logic          host_gnt_a, host_gnt_b, mem_we_a, mem_we_b;
  logic [7:0]    host_rdata_a, host_rdata_b, mem_wdata_a, mem_wdata_b;
  logic [7:0]    mem_rdata_a, mem_rdata_b;
  logic          busy_a, busy_b, done_a, done_b, timeout_a, timeout_b;
  logic [CW-1:0] cnt_a, cnt_b;
  run_state_t    st_a, st_b;
  logic [7:0]    mem_a [256];
  logic [7:0]    mem_b [256];

  always @(posedge clk) begin
    pc_a <= core_start_a ? pc_base : pc_a + pc_step;
    pc_b <= core_start_b ? pc_base : pc_b + pc_step;
  end

  assign core_we_a   = (pc_a == 12'd7) || (pc_a == 12'd100);
  assign core_we_b   = (pc_b == 12'd7) || (pc_b == 12'd100);
  assign core_addr_a = (pc_a == 12'd7) ? 8'd9 : 8'd3;
  assign core_addr_b = (pc_b == 12'd7) ? 8'd9 : 8'd3;
  assign mem_rdata_a = mem_a[mem_addr_a];
  assign mem_rdata_b = mem_b[mem_addr_b];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'h00;
        mem_b[i] <= 8'h00;
      end
    end else begin
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
  end

  run_sequencer #(.D(D), .AW(AW), .DONE_PC(DONE_PC_DEFAULT), .CW(CW),
                  .TIMEOUT(TIMEOUT_DEFAULT)) dut_a (
    .clk(clk), .rst_n(rst_n), .host_go(host_go), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_a), .host_rdata(host_rdata_a), .core_addr(core_addr_a),
    .core_wdata(8'h11), .core_we(core_we_a), .core_pc(pc_a),
    .core_start(core_start_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_we(mem_we_a), .mem_rdata(mem_rdata_a), .busy(busy_a), .done(done_a),
    .timeout(timeout_a), .cycle_cnt(cnt_a), .state_dbg(st_a)
  );

  run_sequencer #(.D(D), .AW(AW), .DONE_PC(DONE_PC_DEFAULT), .CW(CW),
                  .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .host_go(host_go), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_b), .host_rdata(host_rdata_b), .core_addr(core_addr_b),
    .core_wdata(8'h11), .core_we(core_we_b), .core_pc(pc_b),
    .core_start(core_start_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_we(mem_we_b), .mem_rdata(mem_rdata_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .cycle_cnt(cnt_b), .state_dbg(st_b)
  );

  // scoreboard
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; host_go = 1'b0; host_req = 1'b0; host_we = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_go();
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
  endtask

  // Ticks from START until the chosen instance reports done or timeout.
  task automatic run_until(input bit sel, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel ? (done_b || timeout_b) : (done_a || timeout_a)) && n < 2000);
    if (n >= 2000) chk("run_bound", 32'(n), 32'd0);
  endtask

  typedef struct {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_gnt;
    logic [7:0] exp_rdata;
    logic       exp_we;
  } hvec_t;

  hvec_t vec [6];
  int    n;
  bit    gnt_seen;

  initial begin
    vec[0] = '{1'b1, 1'b1, 8'h03, 8'h5A, 1'b1, 8'h00, 1'b1};
    vec[1] = '{1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 8'h5A, 1'b0};
    vec[2] = '{1'b1, 1'b1, 8'hFF, 8'hC3, 1'b1, 8'h00, 1'b1};
    vec[3] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'hC3, 1'b0};
    vec[5] = '{1'b0, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0};

    host_addr = '0; host_wdata = '0; pc_base = '0; pc_step = 12'd1;
    mem_clr = 1'b1;
    do_reset();
    mem_clr = 1'b0;
    #2;
    chk("rst_state", 32'(st_a), 32'(ST_IDLE));
    chk("rst_core_start", 32'(core_start_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_timeout", 32'(timeout_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_gnt", 32'(host_gnt_a), 32'd0);
    chk("rst_mem_we", 32'(mem_we_a), 32'd0);

    for (int i = 0; i < 6; i++) begin
      host_req = vec[i].req; host_we = vec[i].we;
      host_addr = vec[i].addr; host_wdata = vec[i].wdata;
      #2;
      chk($sformatf("vec%0d_gnt", i), 32'(host_gnt_a), 32'(vec[i].exp_gnt));
      chk($sformatf("vec%0d_rdata", i), 32'(host_rdata_a), 32'(vec[i].exp_rdata));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we_a), 32'(vec[i].exp_we));
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr_a), 32'(vec[i].addr));
      chk($sformatf("vec%0d_core_start", i), 32'(core_start_a), 32'd1);
      tick();
    end

    // Full run with host request held throughout; core stores 0x11 to addr 3 at pc 100.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h03; host_wdata = 8'hEE;
    pulse_go();
    #2;
    chk("start_busy", 32'(busy_a), 32'd1);
    chk("start_core_start", 32'(core_start_a), 32'd1);
    chk("start_gnt", 32'(host_gnt_a), 32'd0);
    chk("start_mem_addr", 32'(mem_addr_a), 32'd0);
    chk("start_mem_we", 32'(mem_we_a), 32'd0);
    n = 0; gnt_seen = 1'b0;
    do begin
      tick();
      n++;
      host_go = (n == 50);
      #2;
      if (n == 1) chk("run1_core_start", 32'(core_start_a), 32'd0);
      if (busy_a && host_gnt_a) gnt_seen = 1'b1;
    end while (!done_a && !timeout_a && n < 2000);
    host_go = 1'b0; host_we = 1'b0;
    #1;
    chk("run_ticks", 32'(n), 32'd462);
    chk("run_done", 32'(done_a), 32'd1);
    chk("run_timeout", 32'(timeout_a), 32'd0);
    chk("run_cnt", 32'(cnt_a), 32'd461);
    chk("run_core_start", 32'(core_start_a), 32'd1);
    chk("run_busy", 32'(busy_a), 32'd0);
    chk("run_no_gnt", 32'(gnt_seen), 32'd0);
    chk("done_gnt", 32'(host_gnt_a), 32'd1);
    chk("done_rdata", 32'(host_rdata_a), 32'h11);
    tick();
    chk("done_cnt_hold", 32'(cnt_a), 32'd461);
    host_req = 1'b0;

    // Reset mid-RUN at cycle_cnt 7; the store to addr 9 in that cycle still lands.
    do_reset();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd9; host_wdata = 8'h00;
    tick();
    host_req = 1'b0; host_we = 1'b0;
    pulse_go();
    n = 0;
    while (cnt_a != 16'd7 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_reach7", 32'(n < 100), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    chk("mid_state", 32'(st_a), 32'(ST_IDLE));
    chk("mid_cnt", 32'(cnt_a), 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_core_start", 32'(core_start_a), 32'd1);
    host_req = 1'b1; host_addr = 8'd9;
    #1;
    chk("mid_store_rdata", 32'(host_rdata_a), 32'h11);
    tick();
    host_req = 1'b0;
    pulse_go();
    run_until(1'b0, n);
    chk("rerun_ticks", 32'(n), 32'd462);
    chk("rerun_done", 32'(done_a), 32'd1);
    chk("rerun_cnt", 32'(cnt_a), 32'd461);

    // dut_b: PC stuck at 5 times out after 16 RUN cycles.
    do_reset();
    pc_base = 12'd5; pc_step = 12'd0;
    pulse_go();
    run_until(1'b1, n);
    chk("to_ticks", 32'(n), 32'd17);
    chk("to_timeout", 32'(timeout_b), 32'd1);
    chk("to_done", 32'(done_b), 32'd0);
    chk("to_cnt", 32'(cnt_b), 32'd16);
    chk("to_core_start", 32'(core_start_b), 32'd1);
    chk("to_busy", 32'(busy_b), 32'd0);
    tick();
    chk("to_cnt_hold", 32'(cnt_b), 32'd16);

    // Restart from FAULT with a host read in the same cycle; PC hits 460 on RUN cycle 16.
    pc_base = 12'd445; pc_step = 12'd1;
    host_go = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h03;
    #2;
    chk("fault_go_gnt", 32'(host_gnt_b), 32'd1);
    tick();
    host_go = 1'b0; host_req = 1'b0;
    #2;
    chk("restart_timeout_clr", 32'(timeout_b), 32'd0);
    chk("restart_busy", 32'(busy_b), 32'd1);
    run_until(1'b1, n);
    chk("tie_ticks", 32'(n), 32'd17);
    chk("tie_done", 32'(done_b), 32'd1);
    chk("tie_timeout", 32'(timeout_b), 32'd0);
    chk("tie_cnt", 32'(cnt_b), 32'd16);

    // PC would hit 460 on RUN cycle 17, one past the timeout.
    pc_base = 12'd444;
    pulse_go();
    #2;
    chk("done_go_clr", 32'(done_b), 32'd0);
    run_until(1'b1, n);
    chk("late_timeout", 32'(timeout_b), 32'd1);
    chk("late_done", 32'(done_b), 32'd0);
    chk("late_cnt", 32'(cnt_b), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Top-level run controller between the host/testbench and the 9-bit-instruction core. It owns a small FSM that parks the core, lets the host preload and read back data memory, and starts the program. It watches the program counter for the done address, enforces a cycle-count timeout, and arbitrates the single `dat_mem` port between host and core so they never drive it in the same cycle.

## Interface
Parameters:
- `D`, 12, program counter width (matches PC/nextPC).
- `AW`, 8, data memory address width.
- `DONE_PC`, 460, PC value that marks program completion.
- `CW`, 16, cycle counter width.
- `TIMEOUT`, 4096, maximum RUN cycles before fault; must satisfy 1 ≤ TIMEOUT < 2^CW.

Ports (one clock `clk`; reset `rst_n` is synchronous and active-low):
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `host_go` in 1: request a program run (level, sampled each cycle).
- `host_req` in 1: host memory access request.
- `host_we` in 1: host write enable (qualified by grant).
- `host_addr` in AW: host memory address.
- `host_wdata` in 8: host write data.
- `host_gnt` out 1: host access performed this cycle.
- `host_rdata` out 8: read data, valid when `host_gnt`.
- `core_addr` in AW: core memory address (ALU result).
- `core_wdata` in 8: core store data.
- `core_we` in 1: core MemWrite.
- `core_pc` in D: core program counter.
- `core_start` out 1: drives nextPC `start`; high holds core at start address.
- `mem_addr` out AW, `mem_wdata` out 8, `mem_we` out 1: to `dat_mem`.
- `mem_rdata` in 8: from `dat_mem` (combinational read).
- `busy` out 1, `done` out 1, `timeout` out 1, `cycle_cnt` out CW: status.

## Operation
- States: IDLE, START, RUN, DONE, FAULT. Reset → IDLE.
- Owner: host in IDLE/DONE/FAULT; nobody in START; core in RUN.
- `core_start` = 1 in every state except RUN.
- `host_gnt` = `host_req` && host-owned state. `mem_we` = `host_we && host_gnt` (host-owned), `core_we` (RUN), 0 (START). `mem_addr`/`mem_wdata` come from the owner; zero in START.
- `host_rdata` = `mem_rdata` when `host_gnt`, else 0.
- IDLE/DONE/FAULT + `host_go` → START. In DONE/FAULT this also clears `done`/`timeout`. A host access in the same cycle is still granted.
- START → RUN unconditionally after 1 cycle; `cycle_cnt` cleared to 0.
- RUN: `cycle_cnt` +1 every cycle.
  - `core_pc == DONE_PC` → DONE.
  - Else if `cycle_cnt == TIMEOUT-1` → FAULT.
  - Done takes priority over timeout in the same cycle.
  - `host_go` is ignored; `host_req` gets no grant and must be held by the host until DONE/FAULT.
- DONE: `done`=1 and `cycle_cnt` held. FAULT: `timeout`=1 and `cycle_cnt` held; the core stays frozen by `core_start`.
- `busy` = state ∈ {START, RUN}.

## Timing
- Reset values: state IDLE; `core_start`=1, `busy`=0, `done`=0, `timeout`=0, `cycle_cnt`=0, `host_gnt`=0 unless `host_req`. `mem_we`=0 unless a granted host write.
- Reset asserted mid-RUN: at the next edge the state goes to IDLE, the counter clears, and the core is re-parked. Any core store in that cycle still reaches memory.
- `host_go` in cycle t → START at t+1 → RUN at t+2, with the first core instruction fetched from the start address in that cycle.
- PC reaches DONE_PC on the k-th RUN cycle → DONE next cycle with `cycle_cnt` = k.
- Timeout → FAULT after exactly TIMEOUT RUN cycles, with `cycle_cnt` = TIMEOUT.
- Host write takes effect at the edge ending the granted cycle. Host read data is combinational in the granted cycle.
- Status outputs are registered (decoded from state regs); grant and mux outputs are combinational.

## Structure
- `run_pkg`: state enum typedef `run_state_t` and the default `DONE_PC`/`TIMEOUT` constants, shared with the top level and the bench.
- One sub-module `dmem_mux`: combinational owner select for addr/wdata/we plus `host_gnt`/`host_rdata` generation, driven by a 2-bit owner code from the FSM.
- The FSM, counter and status registers stay in `run_sequencer`.

## Test plan
- Reset, then host writes 0x5A to addr 3 and reads it back while IDLE → `host_gnt`=1 both cycles, `host_rdata`=0x5A, `core_start`=1, `busy`=0.
- `host_go` pulse; core model steps PC 0,1,2…, reaching 460 on RUN cycle 461 → `done`=1, `cycle_cnt`=461, `core_start`=1 again.
- Host `host_req` held during RUN while the core stores 0x11 to addr 3 → `host_gnt`=0 throughout RUN. Grant returns in DONE and the host read gives 0x11.
- PC model stuck at 5 with TIMEOUT=16 → FAULT after 16 RUN cycles, `timeout`=1, `cycle_cnt`=16, `done`=0.
- PC reaches 460 on the same cycle `cycle_cnt`=TIMEOUT-1 → DONE, not FAULT.
- `rst_n`=0 for one cycle mid-RUN at `cycle_cnt`=7 → next cycle IDLE, `cycle_cnt`=0, `busy`=0, `core_start`=1. A following `host_go` runs normally.
